channel_map_sequencer: RTL and testbench

Controller that owns the physical-to-logical channel map applied by the channel-mapping datapath. It collects per-entry writes into a shadow map and checks that the shadow map is a valid permutation. It then commits the whole map atomically on an acquisition frame boundary, so no sample frame ever sees a half-updated or duplicate mapping. It sits between the CSR decode logic and the mapping mux, in the mux's clock domain.

---
 rtl/channel_map_pkg.sv | 30 +++
 rtl/channel_map_checker.sv | 57 +++++
 rtl/channel_map_sequencer.sv | 149 ++++++++++++++
 tb/tb_channel_map_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/channel_map_pkg.sv
// Shared definitions for the channel-map sequencer and the mapping datapath:
// channel limits, sequencer states and the identity map used at reset.
package channel_map_pkg;

    localparam int MAX_CHANNELS  = 8;
    localparam int OPERAND_WIDTH = 3;
    localparam int MAP_WIDTH     = 32;

    // Identity map for all eight channels: entry i holds the value i.
    localparam logic [MAP_WIDTH-1:0] IDENTITY_MAP = 32'h00FA_C688;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WAIT_FRAME
    } seq_state_t;

    // Bit mask covering the entries of the first num_channels channels.
    function automatic logic [MAP_WIDTH-1:0] map_mask(input int num_channels);
        logic [MAP_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_CHANNELS; i++) begin
            if (i < num_channels) begin
                mask[i*OPERAND_WIDTH +: OPERAND_WIDTH] = '1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/channel_map_checker.sv
// Iterative permutation validator. It walks the shadow map one entry per
// cycle while active. An entry is bad if its physical value is out of range
// or has already been claimed by an earlier entry. done/error are
// combinational so the sequencer can leave CHECK on the edge that evaluates
// the last entry.
module channel_map_checker
    import channel_map_pkg::*;
#(
    parameter int NUM_CHANNELS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 active,
    input  logic [MAP_WIDTH-1:0] map,
    output logic                 done,
    output logic                 error
);

    localparam logic [OPERAND_WIDTH:0]   CHAN_LIMIT = (OPERAND_WIDTH+1)'(NUM_CHANNELS);
    localparam logic [OPERAND_WIDTH-1:0] LAST_IDX   = OPERAND_WIDTH'(NUM_CHANNELS - 1);

    logic [OPERAND_WIDTH-1:0] idx;
    logic [MAX_CHANNELS-1:0]  seen;
    logic                     err_acc;
    logic [OPERAND_WIDTH-1:0] entry_value;
    logic                     entry_bad;

    // Classify the entry under the index against range and the seen-mask.
    always_comb begin
        entry_value = map[int'(idx)*OPERAND_WIDTH +: OPERAND_WIDTH];
        entry_bad   = ({1'b0, entry_value} >= CHAN_LIMIT) || seen[entry_value];
        done        = active && (idx == LAST_IDX);
        error       = err_acc || entry_bad;
    end

    // Advance the index and record claimed physical channels or failures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            seen    <= '0;
            err_acc <= 1'b0;
        end else if (start) begin
            idx     <= '0;
            seen    <= '0;
            err_acc <= 1'b0;
        end else if (active) begin
            idx <= idx + 1'b1;
            if (entry_bad) begin
                err_acc <= 1'b1;
            end else begin
                seen[entry_value] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/channel_map_sequencer.sv
// Owns the shadow and active channel maps. Writes land in the shadow map
// while idle, a commit request validates the shadow map as a permutation,
// and a valid map is copied into the active map on the next frame boundary
// so no frame ever sees a partial or duplicate mapping.
module channel_map_sequencer
    import channel_map_pkg::*;
#(
    parameter int NUM_CHANNELS  = 8,
    parameter int OPERAND_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wrStrobe,
    input  logic [OPERAND_WIDTH-1:0] wrLogical,
    input  logic [OPERAND_WIDTH-1:0] wrPhysical,
    input  logic                     commitReq,
    input  logic                     abortReq,
    input  logic                     frameStart,
    output logic [MAP_WIDTH-1:0]     channelMap,
    output logic [MAP_WIDTH-1:0]     shadowMap,
    output logic                     busy,
    output logic                     permError,
    output logic                     writeDropped,
    output logic                     commitDone,
    output logic [15:0]              commitCount
);

    if (NUM_CHANNELS < 1 || NUM_CHANNELS > MAX_CHANNELS) begin : g_bad_channels
        $error("channel_map_sequencer: NUM_CHANNELS must be 1..8");
    end

    if (OPERAND_WIDTH != channel_map_pkg::OPERAND_WIDTH) begin : g_bad_width
        $error("channel_map_sequencer: OPERAND_WIDTH must be 3");
    end

    localparam logic [MAP_WIDTH-1:0]   RESET_MAP  = IDENTITY_MAP & map_mask(NUM_CHANNELS);
    localparam logic [OPERAND_WIDTH:0] CHAN_LIMIT = (OPERAND_WIDTH+1)'(NUM_CHANNELS);

    seq_state_t state;
    seq_state_t next_state;

    logic start_check;
    logic do_commit;
    logic set_perm;
    logic write_ok;
    logic write_drop;
    logic chk_done;
    logic chk_error;

    channel_map_checker #(
        .NUM_CHANNELS (NUM_CHANNELS)
    ) u_checker (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_check),
        .active (state == CHECK),
        .map    (shadowMap),
        .done   (chk_done),
        .error  (chk_error)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection; abort beats a simultaneous frame boundary.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (commitReq) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if (chk_done) begin
                    next_state = chk_error ? IDLE : WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (abortReq || frameStart) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Per-state control strobes for the map, flag and counter registers.
    always_comb begin
        start_check = (state == IDLE) && commitReq;
        do_commit   = (state == WAIT_FRAME) && frameStart && !abortReq;
        set_perm    = (state == CHECK) && chk_done && chk_error;
        write_ok    = (state == IDLE) && wrStrobe && ({1'b0, wrLogical} < CHAN_LIMIT);
        write_drop  = (state != IDLE) && wrStrobe;
    end

    // Shadow map takes accepted entry writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadowMap <= RESET_MAP;
        end else if (write_ok) begin
            shadowMap[int'(wrLogical)*OPERAND_WIDTH +: OPERAND_WIDTH] <= wrPhysical;
        end
    end

    // Active map, commit pulse and commit counter move together on a commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            channelMap  <= RESET_MAP;
            commitDone  <= 1'b0;
            commitCount <= '0;
        end else begin
            commitDone <= do_commit;
            if (do_commit) begin
                channelMap  <= shadowMap;
                commitCount <= commitCount + 16'd1;
            end
        end
    end

    // Sticky status flags, cleared when a new commit starts, plus busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            permError    <= 1'b0;
            writeDropped <= 1'b0;
            busy         <= 1'b0;
        end else begin
            busy <= (next_state != IDLE);
            if (start_check) begin
                permError    <= 1'b0;
                writeDropped <= 1'b0;
            end else begin
                if (set_perm) begin
                    permError <= 1'b1;
                end
                if (write_drop) begin
                    writeDropped <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_channel_map_sequencer.sv
// Directed bench for channel_map_sequencer with eight channels.
module tb_channel_map_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wrStrobe = 1'b0;
    logic [2:0]  wrLogical = '0;
    logic [2:0]  wrPhysical = '0;
    logic        commitReq = 1'b0;
    logic        abortReq = 1'b0;
    logic        frameStart = 1'b0;
    logic [31:0] channelMap;
    logic [31:0] shadowMap;
    logic        busy;
    logic        permError;
    logic        writeDropped;
    logic        commitDone;
    logic [15:0] commitCount;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [31:0] MAP_IDENT   = 32'h00FA_C688;
    localparam logic [31:0] MAP_REVERSE = 32'h0005_3977;
    localparam logic [31:0] MAP_DUP     = 32'h0005_3B77;
    localparam logic [31:0] MAP_ENDS    = 32'h00E5_3970;
    localparam logic [31:0] MAP_SWAP01  = 32'h00FA_C681;

    channel_map_sequencer #(
        .NUM_CHANNELS  (8),
        .OPERAND_WIDTH (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wrStrobe     (wrStrobe),
        .wrLogical    (wrLogical),
        .wrPhysical   (wrPhysical),
        .commitReq    (commitReq),
        .abortReq     (abortReq),
        .frameStart   (frameStart),
        .channelMap   (channelMap),
        .shadowMap    (shadowMap),
        .busy         (busy),
        .permError    (permError),
        .writeDropped (writeDropped),
        .commitDone   (commitDone),
        .commitCount  (commitCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [2:0] l, input logic [2:0] p);
        wrStrobe = 1'b1;
        wrLogical = l;
        wrPhysical = p;
        tick();
        wrStrobe = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        tests_run++; if (channelMap !== MAP_IDENT) begin tests_failed++; $display("[TB] FAIL reset_channelMap: got %h expected %h", channelMap, MAP_IDENT); end
        tests_run++; if (shadowMap !== MAP_IDENT) begin tests_failed++; $display("[TB] FAIL reset_shadowMap: got %h expected %h", shadowMap, MAP_IDENT); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (commitCount !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_commitCount: got %h expected 0000", commitCount); end
        tests_run++; if ({permError, writeDropped, commitDone} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_flags: got %b expected 000", {permError, writeDropped, commitDone}); end
    endtask

    task automatic test_reverse_commit();
        int pulses;
        for (int i = 0; i < 8; i++) write_entry(3'(i), 3'(7 - i));
        tests_run++; if (shadowMap !== MAP_REVERSE) begin tests_failed++; $display("[TB] FAIL rev_shadow: got %h expected %h", shadowMap, MAP_REVERSE); end
        tests_run++; if (channelMap !== MAP_IDENT) begin tests_failed++; $display("[TB] FAIL rev_active_before: got %h expected %h", channelMap, MAP_IDENT); end
        commitReq = 1'b1;
        tick();
        commitReq = 1'b0;
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL rev_busy: got %b expected 1", busy); end
        pulses = 0;
        repeat (19) begin
            tick();
            if (commitDone) pulses++;
        end
        tests_run++; if (pulses !== 0 || channelMap !== MAP_IDENT) begin tests_failed++; $display("[TB] FAIL rev_wait: pulses %0d map %h expected 0 and %h", pulses, channelMap, MAP_IDENT); end
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        tests_run++; if (channelMap !== MAP_REVERSE) begin tests_failed++; $display("[TB] FAIL rev_commit_map: got %h expected %h", channelMap, MAP_REVERSE); end
        tests_run++; if (commitDone !== 1'b1) begin tests_failed++; $display("[TB] FAIL rev_commitDone: got %b expected 1", commitDone); end
        tests_run++; if (commitCount !== 16'd1) begin tests_failed++; $display("[TB] FAIL rev_count: got %h expected 0001", commitCount); end
        tests_run++; if (busy !== 1'b0 || permError !== 1'b0) begin tests_failed++; $display("[TB] FAIL rev_idle: busy %b permError %b expected 0 0", busy, permError); end
        tick();
        tests_run++; if (commitDone !== 1'b0) begin tests_failed++; $display("[TB] FAIL rev_pulse_width: got %b expected 0", commitDone); end
    endtask

    task automatic test_duplicate();
        wrStrobe = 1'b1;
        wrLogical = 3'd3;
        wrPhysical = 3'd5;
        commitReq = 1'b1;
        tick();
        wrStrobe = 1'b0;
        commitReq = 1'b0;
        tests_run++; if (shadowMap !== MAP_DUP) begin tests_failed++; $display("[TB] FAIL dup_shadow: got %h expected %h", shadowMap, MAP_DUP); end
        repeat (7) tick();
        tests_run++; if (busy !== 1'b1 || permError !== 1'b0) begin tests_failed++; $display("[TB] FAIL dup_edge7: busy %b permError %b expected 1 0", busy, permError); end
        tick();
        tests_run++; if (permError !== 1'b1) begin tests_failed++; $display("[TB] FAIL dup_permError: got %b expected 1", permError); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL dup_busy: got %b expected 0", busy); end
        tests_run++; if (channelMap !== MAP_REVERSE) begin tests_failed++; $display("[TB] FAIL dup_active: got %h expected %h", channelMap, MAP_REVERSE); end
    endtask

    task automatic test_ignored_frame_and_drop();
        int pulses;
        write_entry(3'd3, 3'd4);
        write_entry(3'd0, 3'd0);
        write_entry(3'd7, 3'd7);
        tests_run++; if (shadowMap !== MAP_ENDS) begin tests_failed++; $display("[TB] FAIL drop_shadow_setup: got %h expected %h", shadowMap, MAP_ENDS); end
        commitReq = 1'b1;
        tick();
        commitReq = 1'b0;
        tests_run++; if (permError !== 1'b0) begin tests_failed++; $display("[TB] FAIL drop_perm_clear: got %b expected 0", permError); end
        frameStart = 1'b1;
        pulses = 0;
        repeat (8) begin
            tick();
            if (commitDone) pulses++;
        end
        frameStart = 1'b0;
        tests_run++; if (pulses !== 0 || channelMap !== MAP_REVERSE || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL drop_frame_in_check: pulses %0d map %h busy %b expected 0 %h 1", pulses, channelMap, busy, MAP_REVERSE); end
        write_entry(3'd1, 3'd0);
        tests_run++; if (writeDropped !== 1'b1) begin tests_failed++; $display("[TB] FAIL drop_flag: got %b expected 1", writeDropped); end
        tests_run++; if (shadowMap !== MAP_ENDS) begin tests_failed++; $display("[TB] FAIL drop_shadow_kept: got %h expected %h", shadowMap, MAP_ENDS); end
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        tests_run++; if (channelMap !== MAP_ENDS || commitDone !== 1'b1) begin tests_failed++; $display("[TB] FAIL drop_commit: map %h done %b expected %h 1", channelMap, commitDone, MAP_ENDS); end
        tests_run++; if (commitCount !== 16'd2 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL drop_count: count %h busy %b expected 0002 0", commitCount, busy); end
    endtask

    task automatic test_abort();
        write_entry(3'd0, 3'd7);
        write_entry(3'd7, 3'd0);
        commitReq = 1'b1;
        tick();
        commitReq = 1'b0;
        tests_run++; if (writeDropped !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_drop_clear: got %b expected 0", writeDropped); end
        abortReq = 1'b1;
        repeat (8) tick();
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL abort_in_check: busy %b expected 1", busy); end
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        abortReq = 1'b0;
        tests_run++; if (busy !== 1'b0 || commitDone !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_wins: busy %b done %b expected 0 0", busy, commitDone); end
        tests_run++; if (channelMap !== MAP_ENDS || commitCount !== 16'd2) begin tests_failed++; $display("[TB] FAIL abort_map: map %h count %h expected %h 0002", channelMap, commitCount, MAP_ENDS); end
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        tests_run++; if (commitDone !== 1'b0 || channelMap !== MAP_ENDS) begin tests_failed++; $display("[TB] FAIL abort_idle_frame: done %b map %h expected 0 %h", commitDone, channelMap, MAP_ENDS); end
    endtask

    task automatic test_reset_midflight();
        commitReq = 1'b1;
        tick();
        commitReq = 1'b0;
        repeat (8) tick();
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_wait_frame: busy %b expected 1", busy); end
        rst_n = 1'b0;
        #2;
        tests_run++; if (channelMap !== MAP_IDENT || shadowMap !== MAP_IDENT) begin tests_failed++; $display("[TB] FAIL rst_maps: active %h shadow %h expected %h", channelMap, shadowMap, MAP_IDENT); end
        tests_run++; if (busy !== 1'b0 || commitCount !== 16'd0) begin tests_failed++; $display("[TB] FAIL rst_state: busy %b count %h expected 0 0000", busy, commitCount); end
        tick();
        rst_n = 1'b1;
        tick();
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        tests_run++; if (commitDone !== 1'b0 || channelMap !== MAP_IDENT) begin tests_failed++; $display("[TB] FAIL rst_no_commit: done %b map %h expected 0 %h", commitDone, channelMap, MAP_IDENT); end
    endtask

    task automatic test_count_wrap();
        force dut.commitCount = 16'hFFFF;
        #1;
        release dut.commitCount;
        tests_run++; if (commitCount !== 16'hFFFF) begin tests_failed++; $display("[TB] FAIL wrap_preload: got %h expected ffff", commitCount); end
        write_entry(3'd0, 3'd1);
        write_entry(3'd1, 3'd0);
        tests_run++; if (shadowMap !== MAP_SWAP01) begin tests_failed++; $display("[TB] FAIL wrap_shadow: got %h expected %h", shadowMap, MAP_SWAP01); end
        commitReq = 1'b1;
        tick();
        commitReq = 1'b0;
        repeat (8) tick();
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        tests_run++; if (commitCount !== 16'h0000) begin tests_failed++; $display("[TB] FAIL wrap_count: got %h expected 0000", commitCount); end
        tests_run++; if (channelMap !== MAP_SWAP01 || commitDone !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_commit: map %h done %b expected %h 1", channelMap, commitDone, MAP_SWAP01); end
    endtask

    initial begin
        test_reset();
        test_reverse_commit();
        test_duplicate();
        test_ignored_frame_and_drop();
        test_abort();
        test_reset_midflight();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
